// File: rtl/lmsm_pkg.sv
// rtl/lmsm_pkg.sv - shared types and constants for the LM/SM sequencer
package lmsm_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int IDX_W_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Memory-op encoding carried on mem_we
    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

endpackage

// File: rtl/lmsm_addr_ctr.sv
// rtl/lmsm_addr_ctr.sv - load/increment transfer address counter
module lmsm_addr_ctr #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_value,
    output logic [ADDR_W-1:0] count
);

    // Load has priority; increment wraps modulo 2^ADDR_W
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// rtl/lmsm_sequencer.sv - LM/SM multi-register transfer sequencer
module lmsm_sequencer
    import lmsm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [IDX_W-1:0]  pe_idx,
    input  logic              pe_ok,
    input  logic              pe_over,
    output logic              direct,
    output logic              enable_holdreg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [IDX_W-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [IDX_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall,
    output logic              done
);

    state_e             state;
    logic               mode;       // 1 = LM
    logic [IDX_W-1:0]   idx;
    logic               last;
    logic [ADDR_W-1:0]  addr;

    logic               accept;
    logic               advance;

    // Accept needs a nonempty mask; advance is a non-last completed transfer
    assign accept  = (state == ST_IDLE) && start && pe_ok;
    assign advance = (state == ST_XFER) && mem_ack && !last;

    lmsm_addr_ctr #(
        .ADDR_W (ADDR_W)
    ) u_addr_ctr (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .inc        (advance),
        .load_value (base_addr),
        .count      (addr)
    );

    // FSM plus per-transfer register index and last-flag tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            mode  <= 1'b0;
            idx   <= '0;
            last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (pe_ok) begin
                            state <= ST_XFER;
                            mode  <= is_load;
                            idx   <= pe_idx;
                            last  <= pe_over;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_XFER: begin
                    if (mem_ack) begin
                        if (last) begin
                            state <= ST_DONE;
                        end else begin
                            idx  <= pe_idx;
                            last <= pe_over;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output decode; everything parks at idle values while reset is held
    always_comb begin
        direct         = 1'b1;
        enable_holdreg = 1'b0;
        mem_req        = 1'b0;
        mem_we         = MEM_OP_READ;
        mem_addr       = '0;
        mem_wdata      = '0;
        rf_raddr       = '0;
        rf_we          = 1'b0;
        rf_waddr       = '0;
        rf_wdata       = '0;
        stall          = 1'b0;
        done           = 1'b0;
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    enable_holdreg = accept;
                    stall          = accept;
                end
                ST_XFER: begin
                    direct         = 1'b0;
                    mem_req        = 1'b1;
                    mem_addr       = addr;
                    mem_we         = mode ? MEM_OP_READ : MEM_OP_WRITE;
                    rf_raddr       = idx;
                    rf_waddr       = idx;
                    stall          = 1'b1;
                    enable_holdreg = mem_ack && !last;
                    if (mode) begin
                        rf_wdata = mem_rdata;
                        rf_we    = mem_ack;
                    end else begin
                        mem_wdata = rf_rdata;
                    end
                end
                ST_DONE: done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb/tb_lmsm_sequencer.sv - self-checking bench for lmsm_sequencer
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_load;
    logic [15:0] base_addr;
    logic [2:0]  pe_idx;
    logic        pe_ok;
    logic        pe_over;
    logic        direct;
    logic        enable_holdreg;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        stall;
    logic        done;

    always #5 clk = ~clk;

    lmsm_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .is_load        (is_load),
        .base_addr      (base_addr),
        .pe_idx         (pe_idx),
        .pe_ok          (pe_ok),
        .pe_over        (pe_over),
        .direct         (direct),
        .enable_holdreg (enable_holdreg),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .rf_raddr       (rf_raddr),
        .rf_rdata       (rf_rdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .stall          (stall),
        .done           (done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starter: lowest set bit of Imm8 or hold register
    logic [7:0] imm8;
    logic [7:0] hold;
    logic [7:0] cur;
    assign cur = direct ? imm8 : hold;

    always_comb begin
        pe_ok  = (cur != 8'd0);
        pe_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cur[i]) pe_idx = 3'(i);
        end
        pe_over = pe_ok && ((cur & (cur - 8'd1)) == 8'd0);
    end

    always @(posedge clk) begin
        if (enable_holdreg) hold <= cur & ~(8'd1 << pe_idx);
    end

    // Register file and memory environment
    logic [15:0] rf_mem [8];
    assign rf_rdata  = rf_mem[rf_raddr];
    assign mem_rdata = mem_addr ^ 16'h5A5A;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 16'hC000 + 16'(i) * 16'h0111;
        end else if (rf_we) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end

    int ack_delay = 0;
    int wait_cnt  = 0;
    assign mem_ack = mem_req && (wait_cnt >= ack_delay);

    always @(posedge clk) begin
        if (!reset || !mem_req || mem_ack) wait_cnt <= 0;
        else                               wait_cnt <= wait_cnt + 1;
    end

    // Model: expected transfer list derived from mask, base and mode
    typedef struct {
        logic [15:0] addr;
        bit          ld;
        logic [2:0]  rg;
        bit          lst;
    } xfer_t;

    xfer_t expq[$];
    int          ack_cnt    = 0;
    int          rf_we_cnt  = 0;
    logic [15:0] last_ack_addr = 16'h0;

    task automatic push_instr(input bit ld, input logic [7:0] mask, input logic [15:0] base);
        int k = 0;
        int n = $countones(mask);
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                xfer_t e;
                e.addr = base + 16'(k);
                e.ld   = ld;
                e.rg   = 3'(i);
                k++;
                e.lst  = (k == n);
                expq.push_back(e);
            end
        end
    endtask

    // Per-cycle compare against the expected transfer list
    always @(negedge clk) begin
        xfer_t e;
        if (reset) begin
            if (rf_we) rf_we_cnt++;
            if (mem_req) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_mem_req: got addr %0h expected no request", mem_addr);
                end else begin
                    e = expq[0];
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_we", mem_we, !e.ld);
                    check("rf_raddr", rf_raddr, e.rg);
                    check("stall_xfer", stall, 1'b1);
                    if (e.ld) check("rf_waddr", rf_waddr, e.rg);
                    if (mem_ack) begin
                        if (e.ld) begin
                            check("rf_we_ack", rf_we, 1'b1);
                            check("rf_wdata", rf_wdata, e.addr ^ 16'h5A5A);
                        end else begin
                            check("rf_we_sm", rf_we, 1'b0);
                            check("mem_wdata", mem_wdata, rf_mem[e.rg]);
                        end
                        check("ehr_ack", enable_holdreg, !e.lst);
                        last_ack_addr = mem_addr;
                        ack_cnt++;
                        void'(expq.pop_front());
                    end else begin
                        check("ehr_wait", enable_holdreg, 1'b0);
                        check("rf_we_wait", rf_we, 1'b0);
                    end
                end
            end else begin
                check("rf_we_idle", rf_we, 1'b0);
            end
        end
    end

    task automatic run_instr(input bit ld, input logic [7:0] mask, input logic [15:0] base,
                             input int dly, output int lat);
        int exp_lat;
        bit fin = 0;
        exp_lat   = (mask == 8'd0) ? 1 : $countones(mask) * (dly + 1) + 1;
        ack_delay = dly;
        imm8      = mask;
        is_load   = ld;
        base_addr = base;
        start     = 1'b1;
        push_instr(ld, mask, base);
        @(negedge clk);
        check("stall_accept", stall, mask != 8'd0);
        check("ehr_accept", enable_holdreg, mask != 8'd0);
        check("req_accept", mem_req, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!fin) begin
            @(negedge clk);
            if (done) begin
                fin = 1;
            end else if (lat >= 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_timeout: got no done after %0d cycles expected %0d", lat, exp_lat);
                fin = 1;
            end else begin
                if (mask != 8'd0) check("stall_busy", stall, 1'b1);
                @(posedge clk); #1;
                lat++;
            end
        end
        check("done_latency", lat, exp_lat);
        check("stall_done", stall, 1'b0);
        check("queue_drained", expq.size(), 0);
        expq.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int a0;
        int dc[2];
        int k;
        int cyc;
        reset     = 1'b0;
        start     = 1'b0;
        is_load   = 1'b0;
        base_addr = 16'h0;
        imm8      = 8'h0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_direct", direct, 1'b1);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_stall", stall, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ehr", enable_holdreg, 1'b0);
        check("rst_rf_we", rf_we, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;

        // LM 0x05 from 0x0100, zero-wait
        rf_we_cnt = 0;
        run_instr(1'b1, 8'h05, 16'h0100, 0, lat);
        check("t1_lat", lat, 3);
        check("t1_rf_we_cnt", rf_we_cnt, 2);
        check("t1_r0", rf_mem[0], 16'h5B5A);
        check("t1_r2", rf_mem[2], 16'h5B5B);

        // SM all registers across the address wrap
        a0 = ack_cnt;
        run_instr(1'b0, 8'hFF, 16'hFFFE, 0, lat);
        check("t2_lat", lat, 9);
        check("t2_acks", ack_cnt - a0, 8);
        check("t2_last_addr", last_ack_addr, 16'h0005);

        // Empty mask
        a0 = ack_cnt;
        run_instr(1'b1, 8'h00, 16'h1234, 0, lat);
        check("t3_lat", lat, 1);
        check("t3_acks", ack_cnt - a0, 0);

        // LM R7 only, three wait cycles
        run_instr(1'b1, 8'h80, 16'h2000, 3, lat);
        check("t4_lat", lat, 5);
        check("t4_r7", rf_mem[7], 16'h7A5A);

        // Sparse SM with one wait cycle per transfer
        run_instr(1'b0, 8'h5A, 16'h0010, 1, lat);
        check("t5_lat", lat, 9);

        // SM 0x0F, reset dropped after the second ack
        a0        = ack_cnt;
        ack_delay = 0;
        imm8      = 8'h0F;
        is_load   = 1'b0;
        base_addr = 16'h0300;
        start     = 1'b1;
        push_instr(1'b0, 8'h0F, 16'h0300);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        expq.delete();
        check("t6_acks_before_reset", ack_cnt - a0, 2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("t6_idle_req", mem_req, 1'b0);
        check("t6_idle_direct", direct, 1'b1);
        check("t6_idle_stall", stall, 1'b0);
        @(posedge clk); #1;
        run_instr(1'b1, 8'h01, 16'h0400, 0, lat);
        check("t6_lat", lat, 2);
        check("t6_r0", rf_mem[0], 16'h5E5A);

        // start held high through DONE: back-to-back LM 0x03
        rf_we_cnt = 0;
        ack_delay = 0;
        imm8      = 8'h03;
        is_load   = 1'b1;
        base_addr = 16'h0500;
        push_instr(1'b1, 8'h03, 16'h0500);
        push_instr(1'b1, 8'h03, 16'h0500);
        start = 1'b1;
        k     = 0;
        cyc   = 0;
        dc[0] = -1;
        dc[1] = -1;
        while (k < 2 && cyc < 60) begin
            @(negedge clk);
            if (done) begin
                dc[k] = cyc;
                k++;
                if (k == 2) start = 1'b0;
            end
            if (k < 2) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        check("t7_done0", dc[0], 3);
        check("t7_done1", dc[1], 7);
        check("t7_rf_we_cnt", rf_we_cnt, 4);
        check("t7_queue", expq.size(), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t7_idle_req", mem_req, 1'b0);
        check("t7_idle_stall", stall, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Control and datapath sequencer for LM/SM (load-multiple / store-multiple) instructions.
- Sits directly downstream of the LM/SM starter and consumes its register index (`pe_idx`), valid (`pe_ok`) and last-register (`pe_over`) outputs.
- Drives the starter's `direct` and `enable_holdreg` controls, so the starter walks the Imm8 mask one register per transfer.
- Issues one memory transaction per selected register, at consecutive addresses from the base address, writing the register file on LM.
- Stalls the pipeline until the whole mask is done.

## Interface
Parameters:
- `DATA_W`, 16: register/memory data width
- `ADDR_W`, 16: memory address width
- `IDX_W`, 3: register index width (8 registers)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low reset: sampled on the rising edge of `clk`, and `reset`=0 resets the block
- `start`  in  1  LM/SM instruction present at this stage; sampled in IDLE only
- `is_load`  in  1  1 = LM, 0 = SM; sampled with `start`
- `base_addr`  in  ADDR_W  first memory address; sampled with `start`
- `pe_idx`  in  IDX_W  starter's current register index
- `pe_ok`  in  1  starter's mask-nonzero flag
- `pe_over`  in  1  starter's "this index is the last one" flag
- `direct`  out  1  starter mux select: 1 = Imm8, 0 = hold register
- `enable_holdreg`  out  1  starter hold-register load enable
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = write (SM)
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  store data
- `mem_rdata`  in  DATA_W  load data; valid with `mem_ack`
- `mem_ack`  in  1  transaction complete
- `rf_raddr`  out  IDX_W  register-file read index (SM)
- `rf_rdata`  in  DATA_W  register-file read data (combinational)
- `rf_we`  out  1  register-file write enable (LM)
- `rf_waddr`  out  IDX_W  register-file write index
- `rf_wdata`  out  DATA_W  register-file write data
- `stall`  out  1  freeze upstream pipeline
- `done`  out  1  one-cycle completion pulse

## Operation
The FSM has three states: IDLE, XFER and DONE.

Latched state:
- `mode`, from `is_load`
- `addr`, ADDR_W
- `idx`, IDX_W
- `last`, 1

IDLE:
- Outputs: `direct`=1, `enable_holdreg`=0.
- `start`=1 and `pe_ok`=0 (empty mask): go to DONE; no memory traffic.
- `start`=1 and `pe_ok`=1:
  - assert `enable_holdreg`=1 this cycle, which loads the starter hold register with the mask minus `pe_idx`;
  - latch `addr`←`base_addr`, `idx`←`pe_idx`, `last`←`pe_over`, `mode`←`is_load`;
  - go to XFER.

XFER:
- Outputs: `direct`=0, `mem_req`=1, `mem_addr`=`addr`, `mem_we`=~`mode`, `rf_raddr`=`idx`.
- SM: `mem_wdata`=`rf_rdata`.
- While `mem_ack`=0: hold every output stable and keep `enable_holdreg`=0.
- On `mem_ack`=1:
  - LM: `rf_we`=1, `rf_waddr`=`idx`, `rf_wdata`=`mem_rdata`, all in the same cycle.
  - If `last`=1, go to DONE.
  - Otherwise assert `enable_holdreg`=1 and latch `idx`←`pe_idx`, `last`←`pe_over` (the starter now presents the next register), and `addr`←`addr`+1.

DONE:
- `done`=1 for one cycle, `stall`=0, then go to IDLE.

Stall and priority rules:
- `stall` = (state==XFER) | (state==IDLE & `start` & `pe_ok`). It is combinational, so the pipeline freezes in the accept cycle.
- Registers are transferred in starter priority order, lowest index first (R0 before R7).
- `addr`+1 is modulo 2^ADDR_W: 0xFFFF wraps to 0x0000.
- `start` is ignored outside IDLE.
- `start` arriving while in DONE is accepted one cycle later, in IDLE.

## Timing
- Reset (`reset`=0 at an edge) takes effect at that edge.
  - FSM goes to IDLE and any in-flight transfer is abandoned.
  - Output values held during and after reset: `direct`=1, `mem_addr`=0, `rf_raddr`=0, `rf_waddr`=0, `mem_wdata`=0, `rf_wdata`=0. All other outputs are 0.
  - The starter hold register is not relied on after reset, because IDLE reads Imm8 directly.
- Accept: request in cycle A, XFER from A+1; the first `mem_req` is seen in cycle A+1.
- Zero-wait memory (`mem_ack` tied high): one transfer per cycle.
  - N registers take N XFER cycles.
  - `done` arrives in cycle A+N+1.
  - `stall` is high for cycles A..A+N.
- Empty mask: `done` in cycle A+1; `stall` never asserted.
- `enable_holdreg` is high only in the accept cycle and in non-last ack cycles. It is never high during a wait cycle.

## Structure
- Shared package `lmsm_pkg` holds:
  - the state enum {IDLE, XFER, DONE};
  - the `IDX_W`, `DATA_W` and `ADDR_W` defaults;
  - the memory-op encoding constants.
- One sub-module, `lmsm_addr_ctr`: an ADDR_W load/increment counter with load, inc and synchronous active-low reset, matching the top-level `reset`.
- The FSM, the output muxing and the idx/last registers stay in the top module.
- The starter is instantiated beside this block at the integration level, not inside it.

## Test plan
- LM, Imm8=0x05, base 0x0100, `mem_ack` always 1: R0←mem[0x0100], R2←mem[0x0101]; `rf_we` pulses twice; `done` at A+3.
- SM, Imm8=0xFF, base 0xFFFE: eight writes at 0xFFFE, 0xFFFF, 0x0000 … 0x0005 with `mem_wdata`=R0…R7 in order.
- Imm8=0x00 with `start`: `done` at A+1; `mem_req` and `stall` stay 0.
- LM, Imm8=0x80, `mem_ack` delayed 3 cycles: a single transfer to R7; `mem_addr` and `rf_waddr` stable throughout the wait; `enable_holdreg` stays 0 after accept.
- SM, Imm8=0x0F: drop `reset` after the second ack. Next cycle is IDLE with `mem_req`=0 and `direct`=1. A new LM with Imm8=0x01 then completes normally.
- `start` held high through DONE: the second instruction is accepted on the cycle after `done`; no lost or duplicated transfer.
